// File: rtl/reg_bus_arbiter_if.sv
// Register-bus arbiter signal bundle: two master request/ack
// channels, the shared register bus, and arbiter status.
interface reg_bus_arbiter_if #(
    parameter int pADDR_WIDTH = 8
);
    logic                   m0_req;
    logic                   m0_lock;
    logic                   m0_write;
    logic [pADDR_WIDTH-1:0] m0_addr;
    logic [7:0]             m0_wdata;
    logic                   m0_ack;
    logic [7:0]             m0_rdata;

    logic                   m1_req;
    logic                   m1_lock;
    logic                   m1_write;
    logic [pADDR_WIDTH-1:0] m1_addr;
    logic [7:0]             m1_wdata;
    logic                   m1_ack;
    logic [7:0]             m1_rdata;

    logic [pADDR_WIDTH-1:0] reg_addr;
    logic [7:0]             reg_wdata;
    logic                   reg_write;
    logic                   reg_read;
    logic [7:0]             reg_datai;

    logic                   owner;
    logic                   busy;
    logic                   locked;
    logic                   lock_timeout;

    modport slave (
        input  m0_req, m0_lock, m0_write, m0_addr, m0_wdata,
        input  m1_req, m1_lock, m1_write, m1_addr, m1_wdata,
        input  reg_datai,
        output m0_ack, m0_rdata, m1_ack, m1_rdata,
        output reg_addr, reg_wdata, reg_write, reg_read,
        output owner, busy, locked, lock_timeout
    );

    modport master (
        output m0_req, m0_lock, m0_write, m0_addr, m0_wdata,
        output m1_req, m1_lock, m1_write, m1_addr, m1_wdata,
        output reg_datai,
        input  m0_ack, m0_rdata, m1_ack, m1_rdata,
        input  reg_addr, reg_wdata, reg_write, reg_read,
        input  owner, busy, locked, lock_timeout
    );
endinterface

// File: rtl/reg_bus_arbiter.sv
// Two-master round-robin arbiter for the 8-bit register bus,
// with optional bus lock and forced lock release on idle timeout.
module reg_bus_arbiter #(
    parameter int pADDR_WIDTH   = 8,
    parameter int pREAD_LATENCY = 2,
    parameter int pLOCK_TIMEOUT = 255
) (
    input  logic             clk_usb,
    input  logic             reset,
    reg_bus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        ACK
    } state_t;

    localparam logic [3:0]  RL_LAST = 4'(pREAD_LATENCY - 1);
    localparam logic [16:0] TMO     = 17'(pLOCK_TIMEOUT);

    state_t                 state_q, state_d;
    logic                   owner_q, owner_d;
    logic                   last_q, last_d;
    logic                   locked_q, locked_d;
    logic                   lto_q, lto_d;
    logic                   wr_q, wr_d;
    logic [pADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]             wdata_q, wdata_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [15:0]            lcnt_q, lcnt_d;
    logic [7:0]             rdata0_q, rdata0_d;
    logic [7:0]             rdata1_q, rdata1_d;

    logic own_req;
    logic tmo;
    logic hold;
    logic e0;
    logic e1;
    logic grant;
    logic gnt_id;

    // State and datapath registers; reset aborts any access in flight.
    always_ff @(posedge clk_usb or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            locked_q <= 1'b0;
            lto_q    <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            lcnt_q   <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            locked_q <= locked_d;
            lto_q    <= lto_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            lcnt_q   <= lcnt_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Arbitration, lock bookkeeping and access sequencing.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        locked_d = locked_q;
        lto_d    = lto_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        lcnt_d   = lcnt_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        own_req  = owner_q ? bus.m1_req : bus.m0_req;
        tmo      = 1'b0;
        hold     = 1'b0;
        e0       = 1'b0;
        e1       = 1'b0;
        grant    = 1'b0;
        gnt_id   = last_q;

        unique case (state_q)
            IDLE: begin
                if (locked_q && !own_req) begin
                    lcnt_d = lcnt_q + 16'd1;
                    if (({1'b0, lcnt_q} + 17'd1) == TMO) begin
                        tmo      = 1'b1;
                        locked_d = 1'b0;
                        lto_d    = 1'b1;
                        lcnt_d   = '0;
                    end
                end
                hold = locked_q && !tmo;
                e0   = bus.m0_req && !(hold && owner_q);
                e1   = bus.m1_req && !(hold && !owner_q);
                if (e0 && e1) begin
                    grant  = 1'b1;
                    gnt_id = !last_q;
                end else if (e0) begin
                    grant  = 1'b1;
                    gnt_id = 1'b0;
                end else if (e1) begin
                    grant  = 1'b1;
                    gnt_id = 1'b1;
                end
                if (grant) begin
                    owner_d = gnt_id;
                    last_d  = gnt_id;
                    lcnt_d  = '0;
                    addr_d  = gnt_id ? bus.m1_addr : bus.m0_addr;
                    wdata_d = gnt_id ? bus.m1_wdata : bus.m0_wdata;
                    wr_d    = gnt_id ? bus.m1_write : bus.m0_write;
                    cnt_d   = RL_LAST;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (wr_q) begin
                    state_d = ACK;
                end else if (cnt_q == 4'd0) begin
                    if (owner_q) begin
                        rdata1_d = bus.reg_datai;
                    end else begin
                        rdata0_d = bus.reg_datai;
                    end
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACK: begin
                locked_d = owner_q ? bus.m1_lock : bus.m0_lock;
                if (wr_q && (addr_q == '0)) begin
                    lto_d = 1'b0;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.reg_addr     = addr_q;
    assign bus.reg_wdata    = wdata_q;
    assign bus.reg_write    = (state_q == XFER) && wr_q;
    assign bus.reg_read     = (state_q == XFER) && !wr_q;
    assign bus.m0_ack       = (state_q == ACK) && !owner_q;
    assign bus.m1_ack       = (state_q == ACK) && owner_q;
    assign bus.m0_rdata     = rdata0_q;
    assign bus.m1_rdata     = rdata1_q;
    assign bus.owner        = owner_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.locked       = locked_q;
    assign bus.lock_timeout = lto_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Bench for reg_bus_arbiter: directed master traffic with a
// scoreboard of expected completions checked by a bus monitor.
module tb_reg_bus_arbiter;

    localparam int AW  = 8;
    localparam int LAT = 2;
    localparam int TMO = 10;

    typedef struct {
        bit         m;
        bit         wr;
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] slave_data = 8'h00;
    int rd_cyc;
    int tests = 0;
    int fails = 0;
    int lat;
    int lat2;
    exp_t sb[$];

    always #5 clk = ~clk;

    reg_bus_arbiter_if #(.pADDR_WIDTH(AW)) bus ();

    reg_bus_arbiter #(
        .pADDR_WIDTH  (AW),
        .pREAD_LATENCY(LAT),
        .pLOCK_TIMEOUT(TMO)
    ) dut (
        .clk_usb(clk),
        .reset  (rst),
        .bus    (bus.slave)
    );

    // Slave model: read data is only valid on the last reg_read cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) rd_cyc <= 0;
        else rd_cyc <= bus.reg_read ? rd_cyc + 1 : 0;
    end

    assign bus.reg_datai = (bus.reg_read && rd_cyc == LAT - 1) ? slave_data : 8'hEE;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input bit m, input bit wr, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        e.m = m;
        e.wr = wr;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic access(input bit m, input bit wr, input bit lk,
                          input logic [7:0] a, input logic [7:0] d,
                          input bit keep, output int l);
        if (m) begin
            bus.m1_write = wr;
            bus.m1_lock = lk;
            bus.m1_addr = a;
            bus.m1_wdata = d;
            bus.m1_req = 1'b1;
        end else begin
            bus.m0_write = wr;
            bus.m0_lock = lk;
            bus.m0_addr = a;
            bus.m0_wdata = d;
            bus.m0_req = 1'b1;
        end
        l = 0;
        while (1) begin
            @(posedge clk);
            #1;
            l++;
            if ((m ? bus.m1_ack : bus.m0_ack) === 1'b1) break;
            if (l >= 100) begin
                tests++;
                fails++;
                $display("FAIL ack_timeout: m%0d got no ack, required ack within 100 cycles", m);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!keep) begin
            if (m) begin
                bus.m1_req = 1'b0;
                bus.m1_lock = 1'b0;
            end else begin
                bus.m0_req = 1'b0;
                bus.m0_lock = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every ack pops one expected completion.
    initial begin
        exp_t e;
        int wcnt;
        int rcnt;
        bit prev_strobe;
        logic [7:0] waddr;
        logic [7:0] wdat;
        logic [7:0] raddr;
        wcnt = 0;
        rcnt = 0;
        prev_strobe = 1'b0;
        waddr = '0;
        wdat = '0;
        raddr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                wcnt = 0;
                rcnt = 0;
                prev_strobe = 1'b0;
            end else begin
                if (bus.m0_ack || bus.m1_ack) begin
                    chk("ack_single", bus.m0_ack && bus.m1_ack, 0);
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL spurious_ack: ack from m%0d, required none", bus.m1_ack);
                    end else begin
                        e = sb.pop_front();
                        chk("ack_owner", bus.m1_ack, e.m);
                        chk("strobe_before_ack", prev_strobe, 1);
                        if (e.wr) begin
                            chk("wr_cycles", wcnt, 1);
                            chk("rd_cycles_on_wr", rcnt, 0);
                            chk("wr_addr", waddr, e.addr);
                            chk("wr_data", wdat, e.data);
                        end else begin
                            chk("rd_cycles", rcnt, LAT);
                            chk("wr_cycles_on_rd", wcnt, 0);
                            chk("rd_addr", raddr, e.addr);
                            chk("rd_data", e.m ? bus.m1_rdata : bus.m0_rdata, e.data);
                        end
                    end
                    wcnt = 0;
                    rcnt = 0;
                end
                if (bus.reg_write) begin
                    wcnt++;
                    waddr = bus.reg_addr;
                    wdat = bus.reg_wdata;
                end
                if (bus.reg_read) begin
                    rcnt++;
                    raddr = bus.reg_addr;
                end
                prev_strobe = bus.reg_write || bus.reg_read;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.m0_req = 0;
        bus.m0_lock = 0;
        bus.m0_write = 0;
        bus.m0_addr = '0;
        bus.m0_wdata = '0;
        bus.m1_req = 0;
        bus.m1_lock = 0;
        bus.m1_write = 0;
        bus.m1_addr = '0;
        bus.m1_wdata = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_owner", bus.owner, 0);
        chk("rst_locked", bus.locked, 0);
        chk("rst_lock_timeout", bus.lock_timeout, 0);
        chk("rst_reg_write", bus.reg_write, 0);
        chk("rst_reg_read", bus.reg_read, 0);
        chk("rst_reg_addr", bus.reg_addr, 0);
        chk("rst_acks", {bus.m0_ack, bus.m1_ack}, 0);
        chk("rst_rdata", {bus.m0_rdata, bus.m1_rdata}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: single write
        push(0, 1, 8'h04, 8'hA5);
        access(0, 1, 0, 8'h04, 8'hA5, 0, lat);
        chk("t1_write_latency", lat, 2);

        // 2: single read
        slave_data = 8'h5A;
        push(0, 0, 8'h04, 8'h5A);
        access(0, 0, 0, 8'h04, 8'h00, 0, lat);
        chk("t2_read_latency", lat, LAT + 1);
        chk("t2_rdata_hold", bus.m0_rdata, 8'h5A);

        // 3: contention right after reset alternates m0 first
        do_reset();
        push(0, 1, 8'h10, 8'h01);
        push(1, 1, 8'h20, 8'h81);
        push(0, 1, 8'h11, 8'h02);
        push(1, 1, 8'h21, 8'h82);
        push(0, 1, 8'h12, 8'h03);
        push(1, 1, 8'h22, 8'h83);
        fork
            begin
                access(0, 1, 0, 8'h10, 8'h01, 1, lat);
                access(0, 1, 0, 8'h11, 8'h02, 1, lat);
                access(0, 1, 0, 8'h12, 8'h03, 0, lat);
            end
            begin
                access(1, 1, 0, 8'h20, 8'h81, 1, lat2);
                access(1, 1, 0, 8'h21, 8'h82, 1, lat2);
                access(1, 1, 0, 8'h22, 8'h83, 0, lat2);
            end
        join

        // 4: locked m1 read burst holds off m0
        slave_data = 8'h3C;
        repeat (4) push(1, 0, 8'h03, 8'h3C);
        push(0, 1, 8'h05, 8'h66);
        fork
            begin
                access(1, 0, 1, 8'h03, 8'h00, 1, lat2);
                access(1, 0, 1, 8'h03, 8'h00, 1, lat2);
                access(1, 0, 1, 8'h03, 8'h00, 1, lat2);
                chk("t4_locked_mid", bus.locked, 1);
                access(1, 0, 0, 8'h03, 8'h00, 0, lat2);
                chk("t4_locked_released", bus.locked, 0);
            end
            begin
                @(posedge clk);
                #1;
                access(0, 1, 0, 8'h05, 8'h66, 0, lat);
            end
        join

        // 5: lock held idle is force-released, m1 granted same cycle
        push(0, 1, 8'h08, 8'h11);
        access(0, 1, 1, 8'h08, 8'h11, 0, lat);
        chk("t5_locked_set", bus.locked, 1);
        push(1, 1, 8'h07, 8'h22);
        fork
            access(1, 1, 0, 8'h07, 8'h22, 0, lat2);
            begin
                for (int i = 0; i < TMO - 1; i++) begin
                    @(posedge clk);
                    #1;
                    chk("t5_hold_busy", bus.busy, 0);
                    chk("t5_hold_locked", bus.locked, 1);
                end
                @(posedge clk);
                #1;
                chk("t5_rel_busy", bus.busy, 1);
                chk("t5_rel_locked", bus.locked, 0);
                chk("t5_rel_timeout", bus.lock_timeout, 1);
                chk("t5_rel_owner", bus.owner, 1);
                chk("t5_rel_write", bus.reg_write, 1);
            end
        join
        chk("t5_timeout_sticky", bus.lock_timeout, 1);
        push(0, 1, 8'h00, 8'h33);
        access(0, 1, 0, 8'h00, 8'h33, 0, lat);
        chk("t5_timeout_cleared", bus.lock_timeout, 0);

        // 6: reset mid-read aborts cleanly
        slave_data = 8'h81;
        push(0, 0, 8'h09, 8'h81);
        access(0, 0, 0, 8'h09, 8'h00, 0, lat);
        chk("t6_rdata", bus.m0_rdata, 8'h81);
        push(0, 1, 8'h0A, 8'h44);
        access(0, 1, 0, 8'h0A, 8'h44, 0, lat);
        chk("t6_rdata_kept_on_write", bus.m0_rdata, 8'h81);
        bus.m0_write = 1'b0;
        bus.m0_addr = 8'h09;
        bus.m0_req = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_pre_read", bus.reg_read, 1);
        rst = 1'b1;
        #1;
        chk("t6_abort_read", bus.reg_read, 0);
        chk("t6_abort_busy", bus.busy, 0);
        chk("t6_abort_ack", {bus.m0_ack, bus.m1_ack}, 0);
        chk("t6_abort_m0_rdata", bus.m0_rdata, 0);
        chk("t6_abort_m1_rdata", bus.m1_rdata, 0);
        bus.m0_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_idle_after_reset", bus.busy, 0);
        slave_data = 8'h42;
        push(0, 0, 8'h0B, 8'h42);
        access(0, 0, 0, 8'h0B, 8'h00, 0, lat);
        chk("t6_next_latency", lat, LAT + 1);
        chk("t6_next_rdata", bus.m0_rdata, 8'h42);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_bus_arbiter.md
Name: reg_bus_arbiter

Overview:
- Shares the internal 8-bit register bus between two masters: master 0 is the USB parallel-bus front end and master 1 is the SAM SPI bridge.
- Sequences each single-beat register read or write onto the bus and returns read data with a one-cycle ack.
- Round-robin arbitration; an optional lock lets one master complete back-to-back accesses (e.g. streaming reads of the sample FIFO register) without interleaving.
- Sits between the master front ends and the register-file slaves inside the top level.

Parameters:
pADDR_WIDTH, 8, register address width
pREAD_LATENCY, 2, cycles reg_read is held before reg_datai is sampled (legal range 1-15)
pLOCK_TIMEOUT, 255, idle cycles after which a held lock is force-released (legal range 1-65535)

Ports:
clk_usb  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous active-high reset
m0_req  input  1  master 0 access request, held until m0_ack
m0_lock  input  1  master 0 requests bus lock
m0_write  input  1  1 = write, 0 = read
m0_addr  input  pADDR_WIDTH  master 0 address
m0_wdata  input  8  master 0 write data
m0_ack  output  1  one-cycle completion pulse to master 0
m0_rdata  output  8  master 0 read data, valid from m0_ack onward
m1_req, m1_lock, m1_write, m1_addr, m1_wdata, m1_ack, m1_rdata  same as m0_* for master 1
reg_addr  output  pADDR_WIDTH  register bus address
reg_wdata  output  8  register bus write data
reg_write  output  1  one-cycle write strobe
reg_read  output  1  read enable, held pREAD_LATENCY cycles
reg_datai  input  8  read data from slaves
owner  output  1  index of last or current granted master
busy  output  1  high when state is not IDLE
locked  output  1  lock currently held by owner
lock_timeout  output  1  sticky; set when a lock is force-released; cleared when any master writes address 0

Behaviour:
Reset values:
- All outputs are 0.
- last_grant = 1, so master 0 wins the first contention.
- State is IDLE, lock cleared, counters cleared.

States: IDLE, XFER, ACK.

IDLE:
- If locked, only the owner's req is considered.
- Otherwise, if exactly one req is high, grant that master.
- If both are high, grant !last_grant.
- On grant, latch the master's addr, wdata and write into reg_addr, reg_wdata and a write flag; set owner and last_grant; go to XFER next cycle.

XFER:
- Write: reg_write = 1 for exactly one cycle, then go to ACK.
- Read: reg_read = 1 for pREAD_LATENCY cycles, counted by a down-counter. reg_datai is captured into the owner's rdata register on the final reg_read cycle, then go to ACK.

ACK:
- mN_ack = 1 for one cycle, for the owner only; the other master's ack stays 0.
- Sample mN_lock: if 1, set locked; if 0, clear locked.
- Return to IDLE.

Latency (grant edge = cycle G, the IDLE cycle in which req is seen):
- Write: reg_write in G+1, ack in G+2.
- Read: reg_read in G+1..G+pREAD_LATENCY, ack in G+pREAD_LATENCY+1.
- Back-to-back throughput: one write per 3 cycles.

Master rules:
- Hold req and the operands stable until ack.
- If req is still high in the cycle after ack, it is a new request.

Read data:
- mN_rdata holds its value until that master's next read completes.
- Writes do not alter it.

Lock timeout:
- While locked and in IDLE with the owner's req low, a 16-bit counter increments.
- The counter resets on any grant.
- When it reaches pLOCK_TIMEOUT: clear locked, set lock_timeout. The other master may be granted in the same cycle.

Clearing lock_timeout:
- Any completed write with address 0 clears it at the ACK cycle.
- If the same cycle also force-releases a lock, the set wins.

Other rules:
- Requests arriving during XFER or ACK are held pending and arbitrated in the next IDLE.
- Reset mid-transaction returns to IDLE and drops all strobes immediately. No ack is issued for the aborted access, and rdata is cleared.

Test Plan:
1. m0 writes addr 0x04 data 0xA5 alone -> reg_write high exactly one cycle at G+1 with reg_addr=0x04, reg_wdata=0xA5; m0_ack at G+2; m1_ack stays 0.
2. m0 reads addr 0x04, slave drives 0x5A, pREAD_LATENCY=2 -> reg_read high at G+1..G+2; m0_ack at G+3 with m0_rdata=0x5A.
3. m0 and m1 requests asserted in the same cycle after reset, each doing 3 writes (reqs kept high) -> grant order m0, m1, m0, m1, m0, m1.
4. m1 reads with m1_lock=1 while m0_req is held high; m1 does 4 consecutive reads of 0x03 then drops lock on the 4th -> all 4 m1 acks precede m0's grant; locked falls at the 4th ack.
5. m0 locks then idles with pLOCK_TIMEOUT=10 while m1 requests -> lock released and lock_timeout=1 after 10 idle cycles, m1 granted the same cycle; later write to addr 0 clears lock_timeout.
6. Assert reset at G+1 of a read -> reg_read=0, busy=0, no ack pulse, rdata=0; the next request after reset completes normally.
